midi_note_tx: RTL and testbench

//   Encodes note-on/note-off events into MIDI channel-voice messages and serialises them as
//   31250-baud UART frames on a single line. Transmit end of the MIDI link whose receive end

---
 rtl/midi_note_tx.sv | 168 ++++++++++++++++
 tb/tb_midi_note_tx.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_note_tx.sv
// MIDI note-on/note-off transmitter: builds a 3-byte channel-voice message (status optionally
// suppressed by running status) and shifts it out as back-to-back 8N1 UART frames.
module midi_note_tx #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 31250,
  parameter int unsigned CHANNEL    = 0,
  parameter int unsigned RUN_STATUS = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       noteValid,
  output logic       noteReady,
  input  logic       noteOn,
  input  logic [6:0] noteNumber,
  input  logic [6:0] noteVelocity,
  output logic       txOut,
  output logic       txBusy,
  output logic       msgDone
);

  localparam int unsigned Div = CLK_HZ / BAUD;
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);
  localparam logic [3:0] Chan = 4'(CHANNEL);

  if (Div < 2) begin : gDivCheck
    $error("midi_note_tx: CLK_HZ/BAUD must be at least 2");
  end

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} stateT;

  stateT           stateQ, stateD;
  logic [CntW-1:0] bitCntQ, bitCntD;
  logic [2:0]      bitIdxQ, bitIdxD;
  logic [1:0]      byteIdxQ, byteIdxD;
  logic            onQ, onD;
  logic [6:0]      numQ, numD;
  logic [6:0]      velQ, velD;
  logic [7:0]      lastStatusQ, lastStatusD;
  logic            lastValidQ, lastValidD;
  logic            txOutQ, txOutD;

  logic            bitEnd;
  logic [7:0]      newStatus;
  logic [7:0]      curStatus;
  logic [7:0]      nextByte;

  function automatic logic [7:0] msgByte(input logic [1:0] idx, input logic on,
                                         input logic [6:0] num, input logic [6:0] vel);
    logic [7:0] b;
    case (idx)
      2'd0:    b = {on ? 4'h9 : 4'h8, Chan};
      2'd1:    b = {1'b0, num};
      default: b = {1'b0, vel};
    endcase
    return b;
  endfunction

  always_comb begin
    stateD      = stateQ;
    bitCntD     = bitCntQ;
    bitIdxD     = bitIdxQ;
    byteIdxD    = byteIdxQ;
    onD         = onQ;
    numD        = numQ;
    velD        = velQ;
    lastStatusD = lastStatusQ;
    lastValidD  = lastValidQ;
    msgDone     = 1'b0;
    bitEnd      = (bitCntQ == CntMax);
    newStatus   = {noteOn ? 4'h9 : 4'h8, Chan};
    curStatus   = {onQ ? 4'h9 : 4'h8, Chan};

    unique case (stateQ)
      StIdle: begin
        if (noteValid) begin
          onD      = noteOn;
          numD     = noteNumber;
          velD     = noteVelocity;
          // Running status: begin at the first data byte when the status would repeat.
          byteIdxD = ((RUN_STATUS != 0) && lastValidQ && (lastStatusQ == newStatus)) ?
                     2'd1 : 2'd0;
          bitCntD  = '0;
          stateD   = StStart;
        end
      end
      StStart: begin
        if (bitEnd) begin
          bitCntD = '0;
          bitIdxD = '0;
          stateD  = StData;
        end else begin
          bitCntD = bitCntQ + 1'b1;
        end
      end
      StData: begin
        if (bitEnd) begin
          bitCntD = '0;
          if (bitIdxQ == 3'd7) begin
            stateD = StStop;
          end else begin
            bitIdxD = bitIdxQ + 3'd1;
          end
        end else begin
          bitCntD = bitCntQ + 1'b1;
        end
      end
      StStop: begin
        if (bitEnd) begin
          bitCntD = '0;
          if (byteIdxQ == 2'd0) begin
            lastStatusD = curStatus;
            lastValidD  = 1'b1;
          end
          if (byteIdxQ == 2'd2) begin
            stateD  = StIdle;
            msgDone = 1'b1;
          end else begin
            byteIdxD = byteIdxQ + 2'd1;
            stateD   = StStart;
          end
        end else begin
          bitCntD = bitCntQ + 1'b1;
        end
      end
      default: stateD = StIdle;
    endcase

    // Line level is registered from the next state so the pin never glitches.
    nextByte = msgByte(byteIdxD, onD, numD, velD);
    unique case (stateD)
      StStart: txOutD = 1'b0;
      StData:  txOutD = nextByte[bitIdxD];
      default: txOutD = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ      <= StIdle;
      bitCntQ     <= '0;
      bitIdxQ     <= '0;
      byteIdxQ    <= '0;
      onQ         <= 1'b0;
      numQ        <= '0;
      velQ        <= '0;
      lastStatusQ <= '0;
      lastValidQ  <= 1'b0;
      txOutQ      <= 1'b1;
    end else begin
      stateQ      <= stateD;
      bitCntQ     <= bitCntD;
      bitIdxQ     <= bitIdxD;
      byteIdxQ    <= byteIdxD;
      onQ         <= onD;
      numQ        <= numD;
      velQ        <= velD;
      lastStatusQ <= lastStatusD;
      lastValidQ  <= lastValidD;
      txOutQ      <= txOutD;
    end
  end

  assign noteReady = (stateQ == StIdle);
  assign txBusy    = ~noteReady;
  assign txOut     = txOutQ;

endmodule

// File: tb/tb_midi_note_tx.sv
// Scoreboard bench for midi_note_tx: three instances (plain, running status, channel 3), a
// mid-bit UART monitor per instance, and a running-status MIDI parser on the received bytes.
module tb_midi_note_tx;

  localparam int unsigned ClkHz = 312500;
  localparam int unsigned Baud  = 31250;

  typedef struct {
    int         k;
    logic [7:0] b;
  } expT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst, noteValid, noteOn, noteReady, txOut, txBusy, msgDone;
  logic [6:0] noteNumber [3];
  logic [6:0] noteVelocity [3];

  int tests = 0;
  int fails = 0;

  expT        expQ[$];
  bit         lastValid [3];
  logic [7:0] lastStat [3];

  logic [7:0] pStatus [3];
  int         pCnt [3];
  logic [6:0] pD1 [3];
  logic [6:0] pNote [3];
  bit         playing [3];
  int         pVel [3];
  int         pFreq [3];

  midi_note_tx #(.CLK_HZ(ClkHz), .BAUD(Baud), .CHANNEL(0), .RUN_STATUS(0)) dutA (
    .clk(clk), .rst(rst[0]), .noteValid(noteValid[0]), .noteReady(noteReady[0]),
    .noteOn(noteOn[0]), .noteNumber(noteNumber[0]), .noteVelocity(noteVelocity[0]),
    .txOut(txOut[0]), .txBusy(txBusy[0]), .msgDone(msgDone[0]));

  midi_note_tx #(.CLK_HZ(ClkHz), .BAUD(Baud), .CHANNEL(0), .RUN_STATUS(1)) dutB (
    .clk(clk), .rst(rst[1]), .noteValid(noteValid[1]), .noteReady(noteReady[1]),
    .noteOn(noteOn[1]), .noteNumber(noteNumber[1]), .noteVelocity(noteVelocity[1]),
    .txOut(txOut[1]), .txBusy(txBusy[1]), .msgDone(msgDone[1]));

  midi_note_tx #(.CLK_HZ(ClkHz), .BAUD(Baud), .CHANNEL(3), .RUN_STATUS(0)) dutC (
    .clk(clk), .rst(rst[2]), .noteValid(noteValid[2]), .noteReady(noteReady[2]),
    .noteOn(noteOn[2]), .noteNumber(noteNumber[2]), .noteVelocity(noteVelocity[2]),
    .txOut(txOut[2]), .txBusy(txBusy[2]), .msgDone(msgDone[2]));

  function automatic logic [3:0] chanOf(input int k);
    return (k == 2) ? 4'd3 : 4'd0;
  endfunction

  function automatic bit rsOf(input int k);
    return (k == 1);
  endfunction

  function automatic int noteFreq(input int n);
    return $rtoi(440000.0 * (2.0 ** ((real'(n) - 69.0) / 12.0)) + 0.5);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic parse(input int k, input logic [7:0] b);
    if (b[7]) begin
      pStatus[k] = b;
      pCnt[k]    = 0;
    end else if (pCnt[k] == 0) begin
      pD1[k]  = b[6:0];
      pCnt[k] = 1;
    end else begin
      pCnt[k] = 0;
      if (pStatus[k][7:4] == 4'h9 && b != 8'h00) begin
        playing[k] = 1'b1;
        pNote[k]   = pD1[k];
        pVel[k]    = int'(b);
        pFreq[k]   = noteFreq(int'(pD1[k]));
      end else if ((pStatus[k][7:4] == 4'h8 || pStatus[k][7:4] == 4'h9) && pD1[k] == pNote[k]) begin
        playing[k] = 1'b0;
      end
    end
  endtask

  // Called on the first low sample of a start bit; every bit must hold for all 10 clocks.
  task automatic rxByte(input int k);
    logic [9:0] bits;
    bit         stable;
    logic [7:0] b;
    expT        e;
    stable = 1'b1;
    bits   = '0;
    for (int i = 0; i < 10; i++) begin
      for (int s = 0; s < 10; s++) begin
        if (i != 0 || s != 0) @(negedge clk);
        if (rst[k] !== 1'b0) return;
        if (s == 0) bits[i] = txOut[k];
        else if (txOut[k] !== bits[i]) stable = 1'b0;
      end
    end
    b = bits[8:1];
    check($sformatf("frame%0d", k), {29'd0, stable, bits[0], bits[9]}, 32'd5);
    if (expQ.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL byte%0d: got 0x%02h, required no byte", k, b);
    end else begin
      e = expQ.pop_front();
      check($sformatf("byteInst%0d", k), k, e.k);
      check($sformatf("byte%0d", k), {24'd0, b}, {24'd0, e.b});
    end
    parse(k, b);
  endtask

  for (genvar g = 0; g < 3; g++) begin : gMon
    initial begin
      forever begin
        @(negedge clk);
        if (rst[g] === 1'b0 && txOut[g] === 1'b0) rxByte(g);
      end
    end
  end

  task automatic pushMsg(input int k, input logic on, input logic [6:0] num,
                         input logic [6:0] vel, output int len);
    logic [7:0] s;
    expT        e;
    s   = {on ? 4'h9 : 4'h8, chanOf(k)};
    e.k = k;
    if (rsOf(k) && lastValid[k] && lastStat[k] == s) begin
      len = 200;
    end else begin
      len = 300;
      e.b = s;
      expQ.push_back(e);
    end
    lastValid[k] = 1'b1;
    lastStat[k]  = s;
    e.b = {1'b0, num};
    expQ.push_back(e);
    e.b = {1'b0, vel};
    expQ.push_back(e);
  endtask

  task automatic waitReady(input int k);
    int n = 0;
    while (noteReady[k] !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (noteReady[k] !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL waitReady%0d: noteReady=%b, required 1 within 1000 cycles", k, noteReady[k]);
    end
  endtask

  // One message with timing checks; junk requests while busy must be ignored.
  task automatic sendMsg(input int k, input logic on, input logic [6:0] num,
                         input logic [6:0] vel);
    int len, doneAt, readyAt, pulses;
    bit busyOk;
    waitReady(k);
    pushMsg(k, on, num, vel, len);
    noteValid[k]    = 1'b1;
    noteOn[k]       = on;
    noteNumber[k]   = num;
    noteVelocity[k] = vel;
    @(negedge clk);
    noteValid[k] = 1'b0;
    check($sformatf("startLatency%0d", k), {31'd0, txOut[k]}, 32'd0);
    doneAt  = 0;
    readyAt = 0;
    pulses  = 0;
    busyOk  = 1'b1;
    for (int c = 1; c <= len + 5 && readyAt == 0; c++) begin
      if (c > 1) @(negedge clk);
      if (msgDone[k] === 1'b1) begin
        pulses++;
        doneAt = c;
      end
      if (txBusy[k] !== ~noteReady[k]) busyOk = 1'b0;
      if (noteReady[k] === 1'b1) begin
        readyAt = c;
      end else if (c >= 2 && c < len) begin
        noteValid[k]    = ($urandom_range(7) == 0);
        noteOn[k]       = 1'($urandom_range(1));
        noteNumber[k]   = 7'($urandom_range(127));
        noteVelocity[k] = 7'($urandom_range(127));
      end else begin
        noteValid[k] = 1'b0;
      end
    end
    noteValid[k] = 1'b0;
    check($sformatf("msgDoneCycle%0d", k), doneAt, len);
    check($sformatf("msgDonePulses%0d", k), pulses, 1);
    check($sformatf("readyCycle%0d", k), readyAt, len + 1);
    check($sformatf("busyIsNotReady%0d", k), {31'd0, busyOk}, 32'd1);
  endtask

  initial begin
    int lenA, lenB, readyAt;
    rst       = 3'b111;
    noteValid = '0;
    noteOn    = '0;
    for (int k = 0; k < 3; k++) begin
      noteNumber[k]   = '0;
      noteVelocity[k] = '0;
      lastValid[k]    = 1'b0;
      lastStat[k]     = '0;
      pStatus[k]      = '0;
      pCnt[k]         = 0;
      pD1[k]          = '0;
      pNote[k]        = '0;
      playing[k]      = 1'b0;
      pVel[k]         = 0;
      pFreq[k]        = 0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rstTxOut%0d", k), {31'd0, txOut[k]}, 32'd1);
      check($sformatf("rstReady%0d", k), {31'd0, noteReady[k]}, 32'd1);
      check($sformatf("rstBusy%0d", k), {31'd0, txBusy[k]}, 32'd0);
      check($sformatf("rstDone%0d", k), {31'd0, msgDone[k]}, 32'd0);
    end
    rst = 3'b000;
    @(negedge clk);

    sendMsg(0, 1'b1, 7'd60, 7'd100);
    sendMsg(2, 1'b0, 7'd69, 7'd0);

    sendMsg(1, 1'b1, 7'd60, 7'd100);
    sendMsg(1, 1'b1, 7'd62, 7'd127);
    sendMsg(1, 1'b0, 7'd62, 7'd0);

    // Request held high across a whole message.
    waitReady(0);
    pushMsg(0, 1'b1, 7'd64, 7'd90, lenA);
    pushMsg(0, 1'b0, 7'd64, 7'd10, lenB);
    noteValid[0]    = 1'b1;
    noteOn[0]       = 1'b1;
    noteNumber[0]   = 7'd64;
    noteVelocity[0] = 7'd90;
    @(negedge clk);
    noteOn[0]       = 1'b0;
    noteVelocity[0] = 7'd10;
    readyAt = 0;
    for (int c = 1; c <= lenA + 5 && readyAt == 0; c++) begin
      if (c > 1) @(negedge clk);
      if (noteReady[0] === 1'b1) readyAt = c;
    end
    check("heldReadyCycle", readyAt, lenA + 1);
    @(negedge clk);
    check("heldAccept", {31'd0, noteReady[0]}, 32'd0);
    check("heldStart", {31'd0, txOut[0]}, 32'd0);
    noteValid[0] = 1'b0;
    waitReady(0);
    repeat (5) @(negedge clk);
    check("heldTwoMsgs", expQ.size(), 0);
    check("heldLen", lenB, 300);

    // Reset in the middle of D1 bit 4 of a status-skipped message.
    sendMsg(1, 1'b1, 7'd60, 7'd100);
    waitReady(1);
    noteValid[1]    = 1'b1;
    noteOn[1]       = 1'b1;
    noteNumber[1]   = 7'd61;
    noteVelocity[1] = 7'd50;
    @(negedge clk);
    noteValid[1] = 1'b0;
    repeat (54) @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    check("midRstTxOut", {31'd0, txOut[1]}, 32'd1);
    check("midRstReady", {31'd0, noteReady[1]}, 32'd1);
    check("midRstBusy", {31'd0, txBusy[1]}, 32'd0);
    #1 rst[1] = 1'b0;
    lastValid[1] = 1'b0;
    sendMsg(1, 1'b1, 7'd60, 7'd100);

    // Loopback through the receive-side parser.
    sendMsg(0, 1'b1, 7'd69, 7'd100);
    check("loopPlayingOn", {31'd0, playing[0]}, 32'd1);
    check("loopVelocity", pVel[0], 100);
    check("loopFrequency", pFreq[0], 440000);
    sendMsg(0, 1'b0, 7'd69, 7'd0);
    check("loopPlayingOff", {31'd0, playing[0]}, 32'd0);

    for (int i = 0; i < 15; i++) begin
      repeat ($urandom_range(3)) @(negedge clk);
      sendMsg(int'($urandom_range(2)), 1'($urandom_range(1)), 7'($urandom_range(127)),
              7'($urandom_range(127)));
    end

    repeat (20) @(negedge clk);
    check("queueEmpty", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
